// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, shift-add unsigned MUL
// that iterates one multiplier bit per clock. All outputs are registered.
module alu_multicycle #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b1010;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    result_d;
  logic                zero_d, ovf_d, busy_d, done_d;

  logic [WIDTH-1:0]    alu_res;
  logic                alu_ovf;
  logic                is_mul;
  logic [WIDTH-1:0]    sum, diff;
  logic [4:0]          shamt;
  logic [PROD_W-1:0]   acc_sum;

  // Single-cycle operation results and flags from the live operands
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    is_mul  = 1'b0;
    sum     = A + B;
    diff    = A - B;
    shamt   = B[4:0];
    case (ALUCtrl)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SLT: alu_res = WIDTH'($signed(A) < $signed(B));
      OP_SLL: alu_res = (32'(shamt) >= WIDTH) ? '0 : (A << shamt);
      OP_MUL: is_mul  = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and registered-output values
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = Result;
    zero_d   = Zero;
    ovf_d    = Overflow;
    busy_d   = Busy;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (is_mul) begin
            mcand_d  = PROD_W'(A);
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = acc_sum[WIDTH-1:0];
          zero_d   = (acc_sum[WIDTH-1:0] == '0);
          ovf_d    = |acc_sum[PROD_W-1:WIDTH];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      Result   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      Result   <= result_d;
      Zero     <= zero_d;
      Overflow <= ovf_d;
      Busy     <= busy_d;
      Done     <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH = 24) with hand-computed expectations.
module tb_alu_multicycle;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [3:0]  ALUCtrl;
  logic [23:0] A;
  logic [23:0] B;
  logic [23:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(24)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .ALUCtrl  (ALUCtrl),
    .A        (A),
    .B        (B),
    .Result   (Result),
    .Zero     (Zero),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Present one op for exactly one accepting edge; returns #1 after that edge.
  task automatic run_op(input logic [3:0] code, input logic [23:0] a, input logic [23:0] b);
    @(negedge Clock);
    ALUCtrl = code;
    A       = a;
    B       = b;
    Start   = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
  endtask

  // After a MUL is accepted, count cycles to Done; also count Busy-high samples.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = (Busy === 1'b1) ? 1 : 0;
    while (Done !== 1'b1 && cycles < 40) begin
      @(posedge Clock);
      #1;
      cycles++;
      if (Busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (Result !== 24'h0 || Zero !== 1'b1 || Overflow !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got R=%h Z=%b O=%b B=%b D=%b want R=000000 Z=1 O=0 B=0 D=0",
               Result, Zero, Overflow, Busy, Done);
    end
  endtask

  task automatic test_add_sub_slt();
    run_op(4'b0010, 24'h7FFFFF, 24'h000001);
    n_checks++;
    if (Result !== 24'h800000 || Overflow !== 1'b1 || Zero !== 1'b0 || Done !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ovf: got R=%h Z=%b O=%b D=%b want R=800000 Z=0 O=1 D=1", Result, Zero, Overflow, Done);
    end
    @(posedge Clock); #1;
    n_checks++;
    if (Done !== 1'b0 || Result !== 24'h800000 || Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL add_hold: got R=%h O=%b D=%b want R=800000 O=1 D=0", Result, Overflow, Done);
    end
    run_op(4'b0010, 24'hFFFFFF, 24'h000001);
    n_checks++;
    if (Result !== 24'h000000 || Zero !== 1'b1 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wrap: got R=%h Z=%b O=%b want R=000000 Z=1 O=0", Result, Zero, Overflow);
    end
    run_op(4'b1010, 24'h000005, 24'h000005);
    n_checks++;
    if (Result !== 24'h000000 || Zero !== 1'b1 || Overflow !== 1'b0 || Done !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero: got R=%h Z=%b O=%b D=%b want R=000000 Z=1 O=0 D=1", Result, Zero, Overflow, Done);
    end
    run_op(4'b1010, 24'h800000, 24'h000001);
    n_checks++;
    if (Result !== 24'h7FFFFF || Zero !== 1'b0 || Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_ovf: got R=%h Z=%b O=%b want R=7fffff Z=0 O=1", Result, Zero, Overflow);
    end
    run_op(4'b0011, 24'hFFFFFF, 24'h000001);
    n_checks++;
    if (Result !== 24'h000001 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL slt_neg: got R=%h O=%b want R=000001 O=0", Result, Overflow);
    end
    run_op(4'b0011, 24'h000001, 24'hFFFFFF);
    n_checks++;
    if (Result !== 24'h000000 || Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL slt_pos: got R=%h Z=%b want R=000000 Z=1", Result, Zero);
    end
  endtask

  task automatic test_logic_shift();
    run_op(4'b0000, 24'hF0F0F0, 24'h3C3C3C);
    n_checks++;
    if (Result !== 24'h303030 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL and: got R=%h O=%b want R=303030 O=0", Result, Overflow);
    end
    run_op(4'b0001, 24'hF0F0F0, 24'h3C3C3C);
    n_checks++;
    if (Result !== 24'hFCFCFC) begin
      n_fail++;
      $display("FAIL or: got R=%h want R=fcfcfc", Result);
    end
    run_op(4'b0101, 24'hF0F0F0, 24'h3C3C3C);
    n_checks++;
    if (Result !== 24'hCCCCCC) begin
      n_fail++;
      $display("FAIL xor: got R=%h want R=cccccc", Result);
    end
    run_op(4'b0110, 24'h000001, 24'h00001E);
    n_checks++;
    if (Result !== 24'h000000 || Zero !== 1'b1 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sll_big: got R=%h Z=%b O=%b want R=000000 Z=1 O=0", Result, Zero, Overflow);
    end
    run_op(4'b0110, 24'h000001, 24'h000017);
    n_checks++;
    if (Result !== 24'h800000 || Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL sll_23: got R=%h Z=%b want R=800000 Z=0", Result, Zero);
    end
    run_op(4'b0110, 24'h000003, 24'hFFFFE4);
    n_checks++;
    if (Result !== 24'h000030) begin
      n_fail++;
      $display("FAIL sll_lowbits: got R=%h want R=000030", Result);
    end
    run_op(4'b1111, 24'h123456, 24'h654321);
    n_checks++;
    if (Result !== 24'h000000 || Zero !== 1'b1 || Overflow !== 1'b0 || Done !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL undef_op: got R=%h Z=%b O=%b D=%b B=%b want R=000000 Z=1 O=0 D=1 B=0",
               Result, Zero, Overflow, Done, Busy);
    end
  endtask

  task automatic test_mul();
    int cyc, bcnt;
    run_op(4'b0100, 24'h001000, 24'h000800);
    n_checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_accept: got B=%b D=%b want B=1 D=0", Busy, Done);
    end
    wait_done(cyc, bcnt);
    n_checks++;
    if (cyc !== 24 || bcnt !== 24) begin
      n_fail++;
      $display("FAIL mul_latency: got cycles=%0d busy=%0d want cycles=24 busy=24", cyc, bcnt);
    end
    n_checks++;
    if (Result !== 24'h800000 || Overflow !== 1'b0 || Zero !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_result: got R=%h Z=%b O=%b B=%b want R=800000 Z=0 O=0 B=0", Result, Zero, Overflow, Busy);
    end
    @(posedge Clock); #1;
    n_checks++;
    if (Done !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_done_pulse: got D=%b want D=0", Done);
    end
  endtask

  task automatic test_mul_disturb();
    int cyc;
    bit early;
    run_op(4'b0100, 24'h001000, 24'h001000);
    cyc   = 0;
    early = 1'b0;
    while (Done !== 1'b1 && cyc < 40) begin
      @(negedge Clock);
      Start   = cyc[0];
      ALUCtrl = (cyc[1]) ? 4'b0010 : 4'b0100;
      A       = 24'(cyc * 24'h010101);
      B       = 24'hFFFFFF - 24'(cyc);
      @(posedge Clock); #1;
      cyc++;
      if (Done !== 1'b1 && Result !== 24'h800000) early = 1'b1;
    end
    Start = 1'b0;
    n_checks++;
    if (cyc !== 24 || early) begin
      n_fail++;
      $display("FAIL mul_ignore_start: got cycles=%0d early_change=%0b want cycles=24 early_change=0", cyc, early);
    end
    n_checks++;
    if (Result !== 24'h000000 || Zero !== 1'b1 || Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_ovf: got R=%h Z=%b O=%b want R=000000 Z=1 O=1", Result, Zero, Overflow);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    run_op(4'b0100, 24'h000003, 24'h000005);
    // Hold an ADD request across the completing edge; it must wait one more edge.
    @(negedge Clock);
    Start   = 1'b1;
    ALUCtrl = 4'b0010;
    A       = 24'h000001;
    B       = 24'h000001;
    wait_done(cyc, bcnt);
    n_checks++;
    if (cyc !== 24 || Result !== 24'h00000F || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_mul: got cycles=%0d R=%h O=%b want cycles=24 R=00000f O=0", cyc, Result, Overflow);
    end
    @(posedge Clock); #1;
    Start = 1'b0;
    n_checks++;
    if (Result !== 24'h000002 || Done !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_add: got R=%h D=%b B=%b want R=000002 D=1 B=0", Result, Done, Busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit saw_done;
    run_op(4'b0100, 24'h001000, 24'h000800);
    repeat (10) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (Result !== 24'h0 || Zero !== 1'b1 || Overflow !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got R=%h Z=%b O=%b B=%b D=%b want R=000000 Z=1 O=0 B=0 D=0",
               Result, Zero, Overflow, Busy, Done);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge Clock); #1;
      if (Done !== 1'b0) saw_done = 1'b1;
    end
    @(negedge Clock);
    Reset = 1'b1;
    repeat (30) begin
      @(posedge Clock); #1;
      if (Done !== 1'b0 || Busy !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_no_done: got stray Done/Busy=1 want none");
    end
    run_op(4'b0010, 24'h000002, 24'h000003);
    n_checks++;
    if (Result !== 24'h000005 || Done !== 1'b1 || Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_add: got R=%h D=%b Z=%b want R=000005 D=1 Z=0", Result, Done, Zero);
    end
  endtask

  initial begin
    Reset   = 1'b0;
    Start   = 1'b0;
    ALUCtrl = 4'b0000;
    A       = '0;
    B       = '0;
    #12;
    test_reset();
    @(negedge Clock);
    Reset = 1'b1;
    test_add_sub_slt();
    test_logic_shift();
    test_mul();
    test_mul_disturb();
    test_back_to_back();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
